// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel edge datapath and its window front end.
package sobel_pkg;

    localparam int unsigned DEF_PIX_W = 8;

    typedef logic [DEF_PIX_W-1:0] pix_t;
    typedef logic [DEF_PIX_W:0]   pix9_t;

    function automatic pix9_t zext(input pix_t p);
        return {1'b0, p};
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixel storage: combinational read of the old word, write of the new word on the same edge.
module sobel_line_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read sees the value stored before this edge's write (read-before-write).
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-window front end: two line buffers, a column shift register and interior-window gating.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             win_valid,
    output logic [PIX_W:0]   p0,
    output logic [PIX_W:0]   p1,
    output logic [PIX_W:0]   p2,
    output logic [PIX_W:0]   p3,
    output logic [PIX_W:0]   p5,
    output logic [PIX_W:0]   p6,
    output logic [PIX_W:0]   p7,
    output logic [PIX_W:0]   p8,
    output logic             frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col, cur_col, next_col;
    logic [RW-1:0] row, cur_row, next_row;
    logic          col_last, row_last, interior;

    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    // Columns c-2 ([0]) and c-1 ([1]); column c is the live {lb2_rd, lb1_rd, in_pix}.
    logic [1:0][PIX_W-1:0] sr_top, sr_mid, sr_bot;

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .en      (in_valid),
        .addr    (cur_col),
        .wr_data (in_pix),
        .rd_data (lb1_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk     (clk),
        .en      (in_valid),
        .addr    (cur_col),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        col_last = (cur_col == COL_LAST);
        row_last = (cur_row == ROW_LAST);
        next_col = col_last ? '0 : cur_col + 1'b1;
        next_row = cur_row;
        if (col_last) begin
            next_row = row_last ? '0 : cur_row + 1'b1;
        end
        interior = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            sr_top     <= '0;
            sr_mid     <= '0;
            sr_bot     <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
            p5 <= '0;
            p6 <= '0;
            p7 <= '0;
            p8 <= '0;
        end else begin
            win_valid  <= in_valid && interior;
            frame_done <= in_valid && row_last && col_last;
            if (in_valid) begin
                col    <= next_col;
                row    <= next_row;
                sr_top <= {lb2_rd, sr_top[1]};
                sr_mid <= {lb1_rd, sr_mid[1]};
                sr_bot <= {in_pix, sr_bot[1]};
                if (interior) begin
                    p0 <= {1'b0, sr_top[0]};
                    p1 <= {1'b0, sr_top[1]};
                    p2 <= {1'b0, lb2_rd};
                    p3 <= {1'b0, sr_mid[0]};
                    p5 <= {1'b0, lb1_rd};
                    p6 <= {1'b0, sr_bot[0]};
                    p7 <= {1'b0, sr_bot[1]};
                    p8 <= {1'b0, in_pix};
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed-plus-random bench for sobel_window_gen on an 8x4 image against an image-array reference model.
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pix = '0;
    logic       win_valid, frame_done;
    logic [8:0] p0, p1, p2, p3, p5, p6, p7, p8;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pix     (in_pix),
        .win_valid  (win_valid),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_win, n_fd;

    // Reference model: the current frame as a 2-D image plus the raster position.
    logic [7:0]  img [H][W];
    int          mr = 0, mc = 0;
    logic        e_valid = 1'b0, e_fd = 1'b0;
    logic [71:0] e_p = '0;

    function automatic logic [8:0] z(input logic [7:0] x);
        return {1'b0, x};
    endfunction

    function automatic logic [71:0] obs_p();
        return {p0, p1, p2, p3, p5, p6, p7, p8};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic v, input logic s, input logic [7:0] d);
        e_valid = 1'b0;
        e_fd    = 1'b0;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = d;
            if (mr >= 2 && mc >= 2) begin
                e_valid = 1'b1;
                e_p = {z(img[mr-2][mc-2]), z(img[mr-2][mc-1]), z(img[mr-2][mc]),
                       z(img[mr-1][mc-2]), z(img[mr-1][mc]),
                       z(img[mr][mc-2]), z(img[mr][mc-1]), z(img[mr][mc])};
            end
            e_fd = (mr == H-1) && (mc == W-1);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_pix   = d;
        @(posedge clk);
        model_accept(v, s, d);
        #1;
        chk("win_valid", 72'(win_valid), 72'(e_valid));
        chk("frame_done", 72'(frame_done), 72'(e_fd));
        chk("window", obs_p(), e_p);
        if (win_valid) n_win++;
        if (frame_done) n_fd++;
    endtask

    // kind: 0 ramp r*8+c, 1 random, 2 constant 255; gaps drive random junk with in_valid low.
    task automatic send_pixels(input int kind, input int first, input int count,
                               input bit sof_first, input int gap_pct);
        logic [7:0] d;
        for (int i = first; i < first + count; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                d = 8'($urandom_range(0, 255));
                step(1'b0, 1'($urandom_range(0, 1)), d);
            end
            case (kind)
                0:       d = 8'(i);
                1:       d = 8'($urandom_range(0, 255));
                default: d = 8'hFF;
            endcase
            step(1'b1, sof_first && (i == first), d);
        end
    endtask

    initial begin
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom_range(0, 255));

        // Reset state
        #12;
        chk("reset_outputs", {62'd0, win_valid, frame_done, 8'd0}, 72'd0);
        chk("reset_window", obs_p(), 72'd0);
        rst_n = 1'b1;

        // Ramp frame, continuous valid, sof on first pixel
        n_win = 0; n_fd = 0;
        send_pixels(0, 0, 19, 1'b1, 0);
        chk("first_win", {62'd0, win_valid, 9'd0}, {62'd0, 1'b1, 9'd0});
        chk("first_win_p", obs_p(),
            {9'd0, 9'd1, 9'd2, 9'd8, 9'd10, 9'd16, 9'd17, 9'd18});
        send_pixels(0, 19, 13, 1'b0, 0);
        chk("last_fd_p8", {62'd0, frame_done, p8}, {62'd0, 1'b1, 9'd31});
        chk("ramp_win_count", 72'(n_win), 72'd12);
        chk("ramp_fd_count", 72'(n_fd), 72'd1);
        step(1'b0, 1'b0, 8'h00);

        // Same ramp with ~50% gaps
        n_win = 0; n_fd = 0;
        send_pixels(0, 0, 32, 1'b1, 50);
        chk("gap_win_count", 72'(n_win), 72'd12);
        chk("gap_fd_count", 72'(n_fd), 72'd1);

        // Two back-to-back random frames, second one without sof
        send_pixels(1, 0, 32, 1'b0, 0);
        n_win = 0; n_fd = 0;
        send_pixels(1, 0, 32, 1'b0, 0);
        chk("frame2_win_count", 72'(n_win), 72'd12);
        chk("frame2_fd_count", 72'(n_fd), 72'd1);

        // sof reasserted at (2,5), then a full frame
        n_fd = 0;
        send_pixels(1, 0, 21, 1'b1, 20);
        n_win = 0;
        send_pixels(1, 0, 32, 1'b1, 20);
        chk("abort_win_count", 72'(n_win), 72'd12);
        chk("abort_fd_count", 72'(n_fd), 72'd1);

        // Asynchronous reset mid-cycle right after accepting (3,3)
        send_pixels(1, 0, 28, 1'b1, 0);
        chk("pre_reset_valid", 72'(win_valid), 72'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", {70'd0, win_valid, frame_done}, 72'd0);
        chk("async_reset_win", obs_p(), 72'd0);
        mr = 0; mc = 0; e_p = '0;
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        n_win = 0; n_fd = 0;
        send_pixels(0, 0, 32, 1'b0, 30);
        chk("post_reset_win_count", 72'(n_win), 72'd12);
        chk("post_reset_fd_count", 72'(n_fd), 72'd1);

        // Constant 255 frame
        n_win = 0;
        send_pixels(2, 0, 32, 1'b1, 10);
        chk("const_win_count", 72'(n_win), 72'd12);
        chk("const_last_window", obs_p(), {8{9'h0FF}});

        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
